// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: fetch-side and decode-side handshake/bus signals of the IF/ID boundary, plus flush
interface if_id_buffer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_pc4;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [31:0] out_inst;
   logic        out_adel;
   logic        flush;
   modport slave (
      input  in_valid, in_pc, in_pc4, in_inst, out_ready, flush,
      output in_ready, out_valid, out_pc, out_pc4, out_inst, out_adel
   );
   modport master (
      output in_valid, in_pc, in_pc4, in_inst, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_pc4, out_inst, out_adel
   );
endinterface

// File: rtl/if_id_buffer.sv
// if_id_buffer: IF/ID pipeline register with one-entry skid slot, flush and fetch address-error flag; IF_ID_PERF_EN adds stall/bubble counters
module if_id_buffer #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000,
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input logic            clk,
   input logic            rst,
   if_id_buffer_if.slave  b
`ifdef IF_ID_PERF_EN
   ,
   output logic [31:0]    stall_cnt,
   output logic [31:0]    bubble_cnt
`endif
);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] inst;
      logic        adel;
   } bundle_t;

   logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   bundle_t main_q, main_d, skid_q, skid_d, in_b;
   logic    accept, drain;

   // next-state of both slots; skid only fills while main is held, so in_ready is pure state
   always_comb begin
      in_b         = '{pc: b.in_pc, pc4: b.in_pc4, inst: b.in_inst, adel: b.in_pc[1:0] != 2'b00};
      accept       = b.in_valid & ~skid_valid_q;
      drain        = main_valid_q & b.out_ready;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (b.flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q || drain) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            skid_valid_d = accept;
            skid_d       = in_b;
         end else begin
            main_valid_d = accept;
            main_d       = in_b;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_d       = in_b;
      end
   end

   // valid bits are the only reset state
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // payload registers carry no reset
   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   assign b.in_ready  = ~skid_valid_q;
   assign b.out_valid = main_valid_q;
   assign b.out_pc    = main_valid_q ? main_q.pc   : RESET_PC;
   assign b.out_pc4   = main_valid_q ? main_q.pc4  : RESET_PC + 32'd4;
   assign b.out_inst  = main_valid_q ? main_q.inst : NOP_INST;
   assign b.out_adel  = main_valid_q & main_q.adel;

`ifdef IF_ID_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

   // stalls: decode holding a valid bundle; bubbles: nothing to offer and no redirect in progress
   always_comb begin
      stall_cnt_d  = stall_cnt_q + {31'd0, main_valid_q & ~b.out_ready};
      bubble_cnt_d = bubble_cnt_q + {31'd0, ~main_valid_q & ~b.flush};
   end

   // counters survive flush, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif
endmodule
